// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches one instruction at a time from instruction memory and holds it for
// the decode stage. The sequence is FETCH (one-cycle request), then WAIT (for
// the read ack), then HOLD (until decode takes the word). The next PC is
// either the sequential PC+4 or a word-aligned branch target.
// If the ack does not arrive within TIMEOUT wait cycles, the request is
// reissued at the same address and imem_timeout pulses for one cycle.
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   rst          in   synchronous, active-high reset
//   imem_req     out  read request (high for the single FETCH cycle)
//   imem_addr    out  [31:0] read address (= PC)
//   imem_ack     in   read data valid (only looked at in WAIT)
//   imem_rdata   in   [31:0] instruction word from memory
//   PCSrc        in   take the branch (sampled when decode consumes)
//   PCTarget     in   [31:0] branch/jump target
//   dec_ready    in   decode consumes the held instruction
//   instr_valid  out  Instr/op/funct fields are valid
//   Instr        out  [31:0] registered instruction word
//   op           out  [6:0]  Instr[6:0]
//   funct3       out  [2:0]  Instr[14:12]
//   funct7       out  Instr[30]
//   PC           out  [31:0] address of Instr
//   PCPlus4      out  [31:0] PC + 4 (wraps modulo 2^32)
//   imem_timeout out  one-cycle pulse in the cycle of a reissued request
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        dec_ready,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        imem_timeout
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // PEND is the fetch-pending state that reset parks in, so the request
    // stays low while rst is held and the first FETCH follows deassertion.
    typedef enum logic [1:0] {
        PEND  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        timeout_reg, timeout_next;
    logic [31:0] pc_plus4;

    // Target low bits are dropped: fetch addresses are always word aligned.
    logic unused_target_bits;
    assign unused_target_bits = &{1'b0, PCTarget[1:0]};

    assign pc_plus4 = pc_reg + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= PEND;
            pc_reg      <= RESET_PC;
            instr_reg   <= NOP;
            cnt_reg     <= 8'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            PEND: begin
                state_next = FETCH;
                cnt_next   = 8'd0;
            end
            FETCH: begin
                // The counter holds the number of the current WAIT cycle, so
                // it starts at 1 on entry and equals TIMEOUT in the last one.
                state_next = WAIT;
                cnt_next   = 8'd1;
            end
            WAIT: begin
                // Ack is checked first so that an ack on the final wait
                // cycle wins over the reissue.
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = HOLD;
                    cnt_next   = 8'd0;
                end else if (cnt_reg == TIMEOUT) begin
                    state_next   = FETCH;
                    cnt_next     = 8'd0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            HOLD: begin
                if (dec_ready) begin
                    pc_next    = PCSrc ? {PCTarget[31:2], 2'b00} : pc_plus4;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = PEND;
            end
        endcase
    end

    // Control outputs come straight from registers: no input reaches them
    // combinationally.
    assign imem_req     = (state_reg == FETCH);
    assign instr_valid  = (state_reg == HOLD);
    assign imem_timeout = timeout_reg;
    assign imem_addr    = pc_reg;
    assign PC           = pc_reg;
    assign PCPlus4      = pc_plus4;
    assign Instr        = instr_reg;
    assign op           = instr_reg[6:0];
    assign funct3       = instr_reg[14:12];
    assign funct7       = instr_reg[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTarget = 32'h0;
    logic        dec_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        imem_timeout;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_pc;
    int          vectors    = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(8'd255)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .dec_ready(dec_ready),
        .instr_valid(instr_valid), .Instr(Instr), .op(op),
        .funct3(funct3), .funct7(funct7), .PC(PC), .PCPlus4(PCPlus4),
        .imem_timeout(imem_timeout)
    );

    // Advance one clock; outputs are sampled 1ns after the rising edge and
    // new inputs are driven from that point for the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an ack in the current WAIT cycle and record the expectation.
    task automatic give_ack(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back('{pc: model_pc, instr: word});
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: req=%b valid=%b tmo=%b required 0/0/0", imem_req, instr_valid, imem_timeout);
        end
        vectors++;
        if (Instr !== NOP || PC !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_regs: Instr=%h PC=%h required %h/%h", Instr, PC, NOP, RESET_PC);
        end
        rst = 1'b0;
        model_pc = RESET_PC;
        step();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
            miscompares++;
            $display("FAIL reset_first_fetch: req=%b addr=%h required 1/%h", imem_req, imem_addr, model_pc);
        end
        $display("reset: first fetch addr=%h", imem_addr);
    endtask

    task automatic test_basic();
        exp_t e;
        step();                       // WAIT 1
        give_ack(32'h0050_0093);      // -> HOLD, two cycles after the request
        vectors++;
        if (instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_valid: instr_valid=%b required 1", instr_valid);
        end
        e = sb.pop_front();
        vectors++;
        if (Instr !== e.instr || PC !== e.pc || PCPlus4 !== e.pc + 32'd4) begin
            miscompares++;
            $display("FAIL basic_word: Instr=%h PC=%h PCPlus4=%h required %h/%h/%h",
                     Instr, PC, PCPlus4, e.instr, e.pc, e.pc + 32'd4);
        end
        vectors++;
        if (op !== 7'h13 || funct3 !== 3'd0 || funct7 !== 1'b0 || PCPlus4 !== 32'd4) begin
            miscompares++;
            $display("FAIL basic_fields: op=%h f3=%h f7=%b PCPlus4=%h required 13/0/0/4", op, funct3, funct7, PCPlus4);
        end
        $display("basic: Instr=%h PC=%h op=%h", Instr, PC, op);
    endtask

    task automatic test_hold_stable();
        logic [31:0] held_instr = Instr;
        logic [31:0] held_pc    = PC;
        dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imem_ack   = i[0];
            imem_rdata = $urandom;
            PCSrc      = ~i[0];
            PCTarget   = $urandom;
            step();
            vectors++;
            if (Instr !== held_instr || PC !== held_pc || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_stable[%0d]: Instr=%h PC=%h req=%b valid=%b required %h/%h/0/1",
                         i, Instr, PC, imem_req, instr_valid, held_instr, held_pc);
            end
        end
        imem_ack = 1'b0;
        $display("hold: 10 stalled cycles, Instr=%h PC=%h", Instr, PC);
    endtask

    task automatic test_branch();
        exp_t e;
        logic [31:0] word = 32'h4020_8133;
        dec_ready = 1'b1;
        PCSrc     = 1'b1;
        PCTarget  = 32'h0000_0103;
        step();                       // -> FETCH
        dec_ready = 1'b0;
        PCSrc     = 1'b0;
        PCTarget  = 32'hDEAD_BEEF;
        model_pc  = 32'h0000_0100;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_addr: req=%b addr=%h valid=%b required 1/%h/0", imem_req, imem_addr, instr_valid, model_pc);
        end
        step();                       // WAIT 1
        step();                       // WAIT 2
        give_ack(word);
        e = sb.pop_front();
        vectors++;
        if (instr_valid !== 1'b1 || Instr !== e.instr || PC !== e.pc || funct7 !== e.instr[30]
            || funct3 !== e.instr[14:12] || op !== e.instr[6:0]) begin
            miscompares++;
            $display("FAIL branch_word: valid=%b Instr=%h PC=%h required 1/%h/%h", instr_valid, Instr, PC, e.instr, e.pc);
        end
        $display("branch: fetched %h from %h", Instr, PC);
    endtask

    task automatic test_wrap();
        exp_t e;
        dec_ready = 1'b1;
        PCSrc     = 1'b1;
        PCTarget  = 32'hFFFF_FFFF;
        step();                       // -> FETCH at FFFFFFFC
        dec_ready = 1'b0;
        PCSrc     = 1'b0;
        model_pc  = 32'hFFFF_FFFC;
        vectors++;
        if (imem_addr !== model_pc) begin
            miscompares++;
            $display("FAIL wrap_target: addr=%h required %h", imem_addr, model_pc);
        end
        step();
        give_ack(32'h0000_0013);
        e = sb.pop_front();
        vectors++;
        if (PC !== e.pc || PCPlus4 !== 32'h0000_0000 || Instr !== e.instr) begin
            miscompares++;
            $display("FAIL wrap_pcplus4: PC=%h PCPlus4=%h required %h/00000000", PC, PCPlus4, e.pc);
        end
        dec_ready = 1'b1;
        PCSrc     = 1'b0;
        step();                       // -> FETCH at 0
        dec_ready = 1'b0;
        model_pc  = model_pc + 32'd4;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
            miscompares++;
            $display("FAIL wrap_next: req=%b addr=%h required 1/%h", imem_req, imem_addr, model_pc);
        end
        $display("wrap: next fetch addr=%h", imem_addr);
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int k = 1; k <= 255; k++) begin
            step();                   // WAIT k
            vectors++;
            if (imem_req !== 1'b0 || imem_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait[%0d]: req=%b tmo=%b required 0/0", k, imem_req, imem_timeout);
            end
        end
        step();                       // reissue
        vectors++;
        if (imem_req !== 1'b1 || imem_timeout !== 1'b1 || imem_addr !== model_pc) begin
            miscompares++;
            $display("FAIL timeout_reissue: req=%b tmo=%b addr=%h required 1/1/%h", imem_req, imem_timeout, imem_addr, model_pc);
        end
        for (int k = 1; k <= 255; k++) begin
            step();
            vectors++;
            if (imem_req !== 1'b0 || imem_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_wait2[%0d]: req=%b tmo=%b required 0/0", k, imem_req, imem_timeout);
            end
        end
        give_ack(32'h00A0_0113);      // ack in the 255th wait cycle
        e = sb.pop_front();
        vectors++;
        if (imem_timeout !== 1'b0 || instr_valid !== 1'b1 || Instr !== e.instr || PC !== e.pc) begin
            miscompares++;
            $display("FAIL timeout_ack_wins: tmo=%b valid=%b Instr=%h PC=%h required 0/1/%h/%h",
                     imem_timeout, instr_valid, Instr, PC, e.instr, e.pc);
        end
        dec_ready = 1'b1;
        PCSrc     = 1'b0;
        step();
        dec_ready = 1'b0;
        model_pc  = model_pc + 32'd4;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc || imem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_next: req=%b addr=%h tmo=%b required 1/%h/0", imem_req, imem_addr, imem_timeout, model_pc);
        end
        $display("timeout: reissue pulse seen, late ack accepted, next addr=%h", imem_addr);
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic        take;
        logic [31:0] tgt;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
                miscompares++;
                $display("FAIL b2b_fetch[%0d]: req=%b addr=%h required 1/%h", i, imem_req, imem_addr, model_pc);
            end
            // Ack and branch inputs in FETCH must be ignored.
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_0000 | i;
            dec_ready  = 1'b1;
            PCSrc      = 1'b1;
            PCTarget   = $urandom;
            step();                   // WAIT 1
            give_ack($urandom);       // HOLD
            e = sb.pop_front();
            vectors++;
            if (instr_valid !== 1'b1 || Instr !== e.instr || PC !== e.pc || op !== e.instr[6:0]) begin
                miscompares++;
                $display("FAIL b2b_word[%0d]: valid=%b Instr=%h PC=%h required 1/%h/%h", i, instr_valid, Instr, PC, e.instr, e.pc);
            end
            take     = $urandom_range(0, 1);
            tgt      = $urandom;
            PCSrc    = take;
            PCTarget = tgt;
            model_pc = take ? {tgt[31:2], 2'b00} : model_pc + 32'd4;
            step();                   // FETCH, three cycles after the last one
            $display("b2b[%0d]: Instr=%h taken=%b next=%h", i, e.instr, take, model_pc);
        end
        dec_ready = 1'b0;
        PCSrc     = 1'b0;
    endtask

    task automatic test_rst_in_wait();
        step();                       // WAIT 1
        rst = 1'b1;
        step();
        rst        = 1'b0;
        imem_ack   = 1'b1;            // late ack after reset
        imem_rdata = 32'hFFFF_FFFF;
        step();
        imem_ack   = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || Instr !== NOP || PC !== RESET_PC) begin
            miscompares++;
            $display("FAIL rst_wait_late_ack: valid=%b Instr=%h PC=%h required 0/%h/%h", instr_valid, Instr, PC, NOP, RESET_PC);
        end
        model_pc = RESET_PC;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
            miscompares++;
            $display("FAIL rst_wait_refetch: req=%b addr=%h required 1/%h", imem_req, imem_addr, model_pc);
        end
        step();
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait_valid: instr_valid=%b required 0", instr_valid);
        end
        $display("rst_in_wait: refetch from %h", model_pc);
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_hold_stable();
        test_branch();
        test_wrap();
        test_timeout();
        test_back_to_back();
        test_rst_in_wait();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter: TIMEOUT, 8'd255, WAIT cycles without ack before the request is reissued.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: imem_req  out  1  instruction memory read request.
REQ-006 SHALL have port: imem_addr  out  32  read address, equal to PC.
REQ-007 SHALL have port: imem_ack  in  1  memory read data valid.
REQ-008 SHALL have port: imem_rdata  in  32  instruction word.
REQ-009 SHALL have port: PCSrc  in  1  branch taken, from control unit.
REQ-010 SHALL have port: PCTarget  in  32  branch/jump target.
REQ-011 SHALL have port: dec_ready  in  1  decode stage consumes current instruction.
REQ-012 SHALL have port: instr_valid  out  1  Instr/op/funct fields valid.
REQ-013 SHALL have port: Instr  out  32  registered instruction word.
REQ-014 SHALL have port: op  out  7  Instr[6:0].
REQ-015 SHALL have port: funct3  out  3  Instr[14:12].
REQ-016 SHALL have port: funct7  out  1  Instr[30].
REQ-017 SHALL have port: PC  out  32  address of Instr.
REQ-018 SHALL have port: PCPlus4  out  32  PC + 4, modulo 2^32.
REQ-019 SHALL have port: imem_timeout  out  1  one-cycle pulse on request reissue.

Function
REQ-020 SHALL implement FSM states FETCH, WAIT, HOLD.
REQ-021 FETCH: imem_req=1, imem_addr=PC, for exactly one cycle; next state WAIT.
REQ-022 WAIT: imem_req=0; wait counter increments each cycle; on imem_ack=1, Instr<=imem_rdata and next state is HOLD.
REQ-023 WAIT with no ack and counter==TIMEOUT: next state FETCH, counter cleared, imem_timeout=1 for that cycle.
REQ-024 HOLD: instr_valid=1; Instr, PC held stable until dec_ready=1.
REQ-025 HOLD with dec_ready=1: PC<=PCSrc ? {PCTarget[31:2],2'b00} : PC+4; instr_valid<=0; next state FETCH.
REQ-026 PCSrc and PCTarget SHALL be sampled only in the HOLD cycle where dec_ready=1; ignored otherwise.
REQ-027 imem_ack SHALL be ignored in FETCH and HOLD; imem_rdata SHALL not alter Instr outside WAIT.
REQ-028 Ack in the same cycle as the timeout condition: ack wins, no reissue, no imem_timeout pulse.
REQ-029 instr_valid, imem_req and imem_timeout SHALL be decoded from registered state, with no combinational input-to-output path.
REQ-030 op, funct3 and funct7 SHALL be pure slices of registered Instr.
REQ-031 Minimum latency: FETCH cycle N, ack in N+1, instr_valid=1 in N+2; minimum throughput one instruction per 3 cycles.
REQ-032 PC+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.

Reset
REQ-033 rst=1 SHALL force state FETCH-pending, PC=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, imem_timeout=0, counter=0.
REQ-034 After reset, the first FETCH cycle SHALL be the cycle following rst deassertion.
REQ-035 rst asserted in WAIT or HOLD SHALL abandon the outstanding access; a late ack after reset SHALL be ignored.

Verification
REQ-036 Reset then ack one cycle after req with rdata=32'h00500093 -> imem_addr=0, instr_valid=1 two cycles after req, op=7'h13, funct3=0, PC=0, PCPlus4=4.
REQ-037 HOLD with dec_ready=1, PCSrc=1, PCTarget=32'h0000_0103 -> next imem_addr=32'h0000_0100.
REQ-038 HOLD with dec_ready=0 for 10 cycles, toggling imem_ack/imem_rdata -> Instr and PC unchanged, no new imem_req.
REQ-039 No ack for 255 WAIT cycles -> imem_timeout pulse, imem_req reasserted at same address; ack on the 255th cycle -> no pulse.
REQ-040 PC=32'hFFFF_FFFC, dec_ready=1, PCSrc=0 -> next imem_addr=32'h0000_0000.
REQ-041 rst in WAIT, ack arrives the cycle after rst -> instr_valid stays 0, next fetch from RESET_PC.
